// File: rtl/roller_rr_arbiter.sv
// Round-robin arbiter + serializer: grants one of NUM_REQ producers, captures its
// NUM-element vector and streams it out as NUM/ROLL_NUM beats tagged with source and last.
module roller_rr_arbiter #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM        = 8,
  parameter  int ROLL_NUM   = 2,
  parameter  int NUM_REQ    = 4,
  localparam int CYCLES     = NUM / ROLL_NUM,
  localparam int SRC_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int BEAT_W     = (CYCLES > 2) ? $clog2(CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [NUM_REQ-1:0][NUM-1:0],
  input  logic [NUM_REQ-1:0]    data_in_valid,
  output logic [NUM_REQ-1:0]    data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [ROLL_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [SRC_W-1:0]      data_out_src,
  output logic                  data_out_last
);

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [DATA_WIDTH-1:0] buf_q [NUM-1:0];
  logic [DATA_WIDTH-1:0] buf_d [NUM-1:0];
  logic [DATA_WIDTH-1:0] out_q [ROLL_NUM-1:0];
  logic [DATA_WIDTH-1:0] out_d [ROLL_NUM-1:0];

  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  logic             beat_is_last;

  // Cyclic search starting at rr_ptr; cand never exceeds 2*NUM_REQ-2, so one
  // conditional subtraction is enough to wrap it back into range.
  always_comb begin
    logic [SRC_W:0] cand;
    // NOTE: every combinationally driven variable gets a default before any branch,
    // otherwise paths that skip the assignment infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      if (!grant_found && data_in_valid[cand[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Ready is gated by reset so producers never see a grant while the block is held.
  always_comb begin
    data_in_ready = '0;
    if (rst && (state_q == IDLE) && grant_found) begin
      data_in_ready[grant_idx] = 1'b1;
    end
  end

  assign beat_is_last = (beat_q == BEAT_W'(CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    beat_d   = beat_q;
    buf_d    = buf_q;
    out_d    = out_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          for (int e = 0; e < NUM; e++) begin
            buf_d[e] = data_in[grant_idx][e];
          end
          for (int k = 0; k < ROLL_NUM; k++) begin
            out_d[k] = data_in[grant_idx][k];
          end
          src_d    = grant_idx;
          beat_d   = '0;
          rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
          state_d  = SERIAL;
        end
      end

      SERIAL: begin
        if (data_out_ready) begin
          if (beat_is_last) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            // Preload the next slice so the output register always holds the
            // beat being presented, and keeps the final beat once back in IDLE.
            for (int b = 0; b < CYCLES - 1; b++) begin
              if (beat_q == BEAT_W'(b)) begin
                for (int k = 0; k < ROLL_NUM; k++) begin
                  out_d[k] = buf_q[(b + 1) * ROLL_NUM + k];
                end
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      beat_q   <= '0;
      // NOTE: the vector buffer is deliberately reset; reset-time outputs are
      // defined as zero, and a dropped vector must not leak into later beats.
      for (int e = 0; e < NUM; e++) begin
        buf_q[e] <= '0;
      end
      for (int k = 0; k < ROLL_NUM; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      beat_q   <= beat_d;
      buf_q    <= buf_d;
      out_q    <= out_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = (state_q == SERIAL);
  assign data_out_src   = src_q;
  assign data_out_last  = (state_q == SERIAL) && beat_is_last;

endmodule

// File: tb/tb_roller_rr_arbiter.sv
// Scoreboard bench for roller_rr_arbiter: stimulus pushes expected grants/beats,
// negedge monitors pop and compare; covers a 4x(8/2) instance and a 3x(4/4) instance.
module tb_roller_rr_arbiter;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  src;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- instance A: NUM_REQ=4, NUM=8, ROLL_NUM=2 ----------------
  logic        rst_a;
  logic [15:0] din_a [3:0][7:0];
  logic [3:0]  vld_a;
  logic [3:0]  rdy_in_a;
  logic [15:0] do_a [1:0];
  logic        dov_a;
  logic        dor_a;
  logic [1:0]  src_a;
  logic        last_a;

  roller_rr_arbiter #(.DATA_WIDTH(16), .NUM(8), .ROLL_NUM(2), .NUM_REQ(4)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .data_in(din_a), .data_in_valid(vld_a), .data_in_ready(rdy_in_a),
    .data_out(do_a), .data_out_valid(dov_a), .data_out_ready(dor_a),
    .data_out_src(src_a), .data_out_last(last_a)
  );

  // ---------------- instance B: NUM_REQ=3, NUM=4, ROLL_NUM=4 ----------------
  logic        rst_b;
  logic [15:0] din_b [2:0][3:0];
  logic [2:0]  vld_b;
  logic [2:0]  rdy_in_b;
  logic [15:0] do_b [3:0];
  logic        dov_b;
  logic        dor_b;
  logic [1:0]  src_b;
  logic        last_b;

  roller_rr_arbiter #(.DATA_WIDTH(16), .NUM(4), .ROLL_NUM(4), .NUM_REQ(3)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .data_in(din_b), .data_in_valid(vld_b), .data_in_ready(rdy_in_b),
    .data_out(do_b), .data_out_valid(dov_b), .data_out_ready(dor_b),
    .data_out_src(src_b), .data_out_last(last_b)
  );

  int    exp_grant_a[$];
  beat_t exp_beat_a[$];
  int    grant_cyc_a[$];
  int    n_grants_a = 0;
  int    n_hs_a     = 0;
  int    exp_grant_b[$];
  beat_t exp_beat_b[$];
  int    n_grants_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- monitor A ----------------
  logic        stall_prev_a = 1'b0;
  logic [34:0] held_a       = '0;

  always @(negedge clk) begin : mon_a
    int    g;
    beat_t e;
    logic [34:0] cur;
    if (!rst_a) begin
      stall_prev_a = 1'b0;
    end else begin
      cur = {do_a[1], do_a[0], src_a, last_a};
      if (rdy_in_a != '0) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (rdy_in_a[i]) g = i;
        check("a_ready_onehot", 64'($onehot(rdy_in_a)), 64'd1);
        check("a_ready_on_valid", 64'(vld_a[g]), 64'd1);
        if (exp_grant_a.size() == 0) fail_event("a_unexpected_grant");
        else check("a_grant_idx", 64'(g), 64'(exp_grant_a.pop_front()));
        grant_cyc_a.push_back(cyc);
        n_grants_a++;
      end
      if (dov_a) begin
        if (stall_prev_a) check("a_stall_hold", 64'(cur), 64'(held_a));
        if (dor_a) begin
          if (exp_beat_a.size() == 0) fail_event("a_extra_beat");
          else begin
            e = exp_beat_a.pop_front();
            check("a_beat_data", {32'h0, do_a[1], do_a[0]}, e.data);
            check("a_beat_src", 64'(src_a), 64'(e.src));
            check("a_beat_last", 64'(last_a), 64'(e.last));
          end
          n_hs_a++;
        end
      end
      stall_prev_a = dov_a && !dor_a;
      held_a       = cur;
    end
  end

  // ---------------- monitor B ----------------
  always @(negedge clk) begin : mon_b
    int    g;
    beat_t e;
    if (rst_b) begin
      if (rdy_in_b != '0) begin
        g = 0;
        for (int i = 0; i < 3; i++) if (rdy_in_b[i]) g = i;
        check("b_ready_onehot", 64'($onehot(rdy_in_b)), 64'd1);
        if (exp_grant_b.size() == 0) fail_event("b_unexpected_grant");
        else check("b_grant_idx", 64'(g), 64'(exp_grant_b.pop_front()));
        n_grants_b++;
      end
      if (dov_b && dor_b) begin
        if (exp_beat_b.size() == 0) fail_event("b_extra_beat");
        else begin
          e = exp_beat_b.pop_front();
          check("b_beat_data", {do_b[3], do_b[2], do_b[1], do_b[0]}, e.data);
          check("b_beat_src", 64'(src_b), 64'(e.src));
          check("b_beat_last", 64'(last_b), 64'(e.last));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_vec_a(input int r);
    beat_t b;
    exp_grant_a.push_back(r);
    for (int k = 0; k < 4; k++) begin
      b.data = {32'h0, din_a[r][2*k+1], din_a[r][2*k]};
      b.src  = 2'(r);
      b.last = (k == 3);
      exp_beat_a.push_back(b);
    end
  endtask

  task automatic push_vec_b(input int r);
    beat_t b;
    exp_grant_b.push_back(r);
    b.data = {din_b[r][3], din_b[r][2], din_b[r][1], din_b[r][0]};
    b.src  = 2'(r);
    b.last = 1'b1;
    exp_beat_b.push_back(b);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    exp_grant_a.delete();
    exp_beat_a.delete();
    grant_cyc_a.delete();
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    n_grants_a = 0;
    n_hs_a     = 0;
  endtask

  task automatic wait_grants_a(input int n);
    int c = 0;
    while (n_grants_a < n && c < 200) begin @(negedge clk); #1; c++; end
    if (n_grants_a < n) fail_event("a_timeout_grants");
  endtask

  task automatic wait_hs_a(input int n);
    int c = 0;
    while (n_hs_a < n && c < 200) begin @(negedge clk); #1; c++; end
    if (n_hs_a < n) fail_event("a_timeout_handshakes");
  endtask

  task automatic wait_drain_a();
    int c = 0;
    while ((exp_beat_a.size() != 0 || exp_grant_a.size() != 0) && c < 300) begin
      @(negedge clk); #1; c++;
    end
    if (exp_beat_a.size() != 0 || exp_grant_a.size() != 0) fail_event("a_timeout_drain");
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_drain_b();
    int c = 0;
    while ((exp_beat_b.size() != 0 || exp_grant_b.size() != 0) && c < 300) begin
      @(negedge clk); #1; c++;
    end
    if (exp_beat_b.size() != 0 || exp_grant_b.size() != 0) fail_event("b_timeout_drain");
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : stim
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst_a = 1'b0; vld_a = 4'b1111; dor_a = 1'b1;
    rst_b = 1'b0; vld_b = 3'b111;  dor_b = 1'b1;
    for (int r = 0; r < 4; r++) for (int e = 0; e < 8; e++) din_a[r][e] = 16'(16'hA000 + r*16 + e);
    for (int r = 0; r < 3; r++) for (int e = 0; e < 4; e++) din_b[r][e] = 16'(16'hB000 + r*16 + e);

    // Reset values with every valid asserted
    #3;
    check("rst_a_ready", 64'(rdy_in_a), 64'd0);
    check("rst_a_valid", 64'(dov_a), 64'd0);
    check("rst_a_last", 64'(last_a), 64'd0);
    check("rst_a_data", {32'h0, do_a[1], do_a[0]}, 64'd0);
    check("rst_a_src", 64'(src_a), 64'd0);
    check("rst_b_ready", 64'(rdy_in_b), 64'd0);
    check("rst_b_valid", 64'(dov_b), 64'd0);

    // Test 1: single requester 2 with data 0..7, regrant after 5 cycles
    vld_a = 4'b0000;
    for (int e = 0; e < 8; e++) din_a[2][e] = 16'(e);
    @(posedge clk); #1 rst_a = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(dov_a), 64'd0);
    check("post_rst_ready", 64'(rdy_in_a), 64'd0);
    push_vec_a(2);
    push_vec_a(2);
    @(posedge clk); #1 vld_a = 4'b0100;
    wait_grants_a(2);
    @(posedge clk); #1 vld_a = 4'b0000;
    wait_drain_a();
    if (grant_cyc_a.size() >= 2) check("regrant_gap", 64'(grant_cyc_a[1] - grant_cyc_a[0]), 64'd5);
    else fail_event("regrant_gap_missing");
    for (int e = 0; e < 8; e++) din_a[2][e] = 16'(16'hA020 + e);

    // Test 2: all valid from reset, order 0,1,2,3,0,1
    vld_a = 4'b1111;
    reset_a();
    push_vec_a(0); push_vec_a(1); push_vec_a(2);
    push_vec_a(3); push_vec_a(0); push_vec_a(1);
    wait_grants_a(6);
    @(posedge clk); #1 vld_a = 4'b0000;
    wait_drain_a();

    // Test 3: rr_ptr=1 with valids 1001 -> 3 wins, then 0, then 3
    vld_a = 4'b0000;
    reset_a();
    push_vec_a(0);
    @(posedge clk); #1 vld_a = 4'b0001;
    wait_grants_a(1);
    @(posedge clk); #1 vld_a = 4'b1001;
    push_vec_a(3); push_vec_a(0); push_vec_a(3);
    wait_grants_a(4);
    @(posedge clk); #1 vld_a = 4'b0000;
    wait_drain_a();

    // Test 4: backpressure pattern 1,0,0,1 on data_out_ready
    reset_a();
    push_vec_a(1);
    @(posedge clk); #1 vld_a = 4'b0010;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (n_grants_a >= 1) vld_a = 4'b0000;
      dor_a = pat[c % 4];
    end
    dor_a = 1'b1;
    wait_drain_a();
    check("bp_handshakes", 64'(n_hs_a), 64'd4);

    // Test 5: reset mid-vector after beat 1
    reset_a();
    push_vec_a(2);
    @(posedge clk); #1 vld_a = 4'b0100;
    wait_grants_a(1);
    @(posedge clk); #1 vld_a = 4'b0000;
    wait_hs_a(2);
    @(posedge clk); #1;
    check("mid_valid_before_rst", 64'(dov_a), 64'd1);
    #1 rst_a = 1'b0;
    #1;
    check("mid_rst_valid_drop", 64'(dov_a), 64'd0);
    check("mid_rst_last_drop", 64'(last_a), 64'd0);
    exp_grant_a.delete();
    exp_beat_a.delete();
    vld_a = 4'b1010;
    @(negedge clk);
    check("mid_rst_ready", 64'(rdy_in_a), 64'd0);
    @(posedge clk); #1 rst_a = 1'b1;
    n_grants_a = 0;
    push_vec_a(1);
    wait_grants_a(1);
    @(posedge clk); #1 vld_a = 4'b0000;
    wait_drain_a();

    // Test 6: NUM_REQ=3, NUM=ROLL_NUM=4, wrap 2 -> 0, last always 1
    vld_b = 3'b111;
    push_vec_b(0); push_vec_b(1); push_vec_b(2);
    push_vec_b(0); push_vec_b(1); push_vec_b(2);
    @(posedge clk); #1 rst_b = 1'b1;
    begin
      int c = 0;
      while (n_grants_b < 6 && c < 200) begin @(negedge clk); #1; c++; end
      if (n_grants_b < 6) fail_event("b_timeout_grants");
    end
    @(posedge clk); #1 vld_b = 3'b000;
    wait_drain_b();
    check("b_idle_valid", 64'(dov_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/roller_rr_arbiter.md
# roller_rr_arbiter

Round-robin arbiter and serializer that shares one NUM-element vector serializer among NUM_REQ producers. It grants one producer at a time, captures that producer's full vector, and emits it as NUM/ROLL_NUM beats of ROLL_NUM elements. Each beat carries a source tag and a last-beat flag. It sits between parallel producers, such as per-channel convolution window buffers, and a single narrow downstream consumer.

## Interface
- DATA_WIDTH, 16, element width in bits
- NUM, 8, elements per input vector; must be a multiple of ROLL_NUM
- ROLL_NUM, 2, elements per output beat
- NUM_REQ, 4, number of requesters; must be at least 2, and need not be a power of 2
- Derived values:
  - CYCLES = NUM/ROLL_NUM
  - SRC_W = max(1, $clog2(NUM_REQ))
  - BEAT_W = max(1, $clog2(CYCLES))

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low; all state is cleared while rst = 0
- data_in  in  [NUM_REQ-1:0][NUM-1:0] x DATA_WIDTH  unpacked per-requester vectors
- data_in_valid  in  NUM_REQ  per-requester valid
- data_in_ready  out  NUM_REQ  per-requester ready; one-hot or zero
- data_out  out  [ROLL_NUM-1:0] x DATA_WIDTH  current beat; element 0 is the lowest index of the slice
- data_out_valid  out  1  beat valid
- data_out_ready  in  1  downstream ready
- data_out_src  out  SRC_W  index of the requester that owns the current beat
- data_out_last  out  1  high on beat CYCLES-1 of a vector

## Operation
- State machine with two states, IDLE and SERIAL.
- **IDLE**
  - g is the first index at or after rr_ptr, searched cyclically, whose data_in_valid is 1.
  - data_in_ready[g] = 1 and all other ready bits are 0. If no valid is asserted, all ready bits are 0.
  - data_in_ready depends combinationally on data_in_valid and rr_ptr. data_in_ready never depends on data_out_ready.
  - data_out_valid = 0.
  - When data_in_valid[g] and data_in_ready[g] are both high at a clock edge:
    - buf <= data_in[g]
    - src <= g
    - beat <= 0
    - rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1
    - state <= SERIAL
- **SERIAL**
  - data_in_ready = 0.
  - data_out_valid = 1.
  - data_out[k] = buf[beat*ROLL_NUM + k].
  - data_out_src = src.
  - data_out_last = (beat == CYCLES-1).
  - On a data_out handshake:
    - If not last, beat <= beat+1.
    - If last, state <= IDLE and beat <= 0.
  - Without a handshake, all outputs hold stable (AXI-style: no retraction, no data change).
- rr_ptr advances only on an input acceptance, never on idle cycles. The winner of each acceptance becomes lowest priority for the next one.
- CYCLES == 1: SERIAL lasts one handshake and data_out_last is always 1 while data_out_valid is 1.
- data_out and data_out_src are don't-care in IDLE. The RTL holds their last values, with reset value 0.

## Timing
- Values during reset (rst = 0) and immediately after release:
  - state = IDLE
  - rr_ptr = 0, beat = 0, src = 0, buf = 0
  - data_out_valid = 0, data_out_last = 0, data_out = 0, data_out_src = 0
  - data_in_ready = 0 while rst = 0, regardless of data_in_valid
- Latency: if input acceptance happens at edge T, the first beat is valid in the cycle after T.
- With data_out_ready held at 1, the last beat handshakes at edge T+CYCLES.
- Throughput: at most one vector per CYCLES+1 cycles. There is one IDLE cycle between vectors, and back-to-back acceptance on the last-beat edge is not supported.
- A requester that deasserts data_in_valid before it is granted simply loses that arbitration. The arbiter keeps no state for that requester.
- Simultaneous valids: exactly one requester is granted, chosen by the rr_ptr rule. The other requesters keep their data_in_valid asserted and wait.
- Downstream stall (data_out_ready = 0) for any number of cycles: beat, buf, src and all outputs are frozen.
- Reset asserted mid-vector: the vector is dropped. data_out_valid falls asynchronously, and after release the block is in IDLE with rr_ptr = 0.

## Test plan
- Single requester, NUM=8, ROLL_NUM=2:
  - Stimulus: requester 2 holds data {0..7} valid; data_out_ready = 1.
  - Response: data_in_ready = 4'b0100 for one cycle.
  - Beats {0,1}, {2,3}, {4,5}, {6,7} appear on consecutive cycles with src = 2, and last is high only on {6,7}.
  - The next grant to requester 2 occurs 5 cycles after the first grant.
- All four requesters valid continuously from reset: grants follow the order 0, 1, 2, 3, 0, 1, with each output vector's src matching its grant.
- Valids 4'b1001 with rr_ptr = 1: requester 3 wins. With rr_ptr then 0, requester 0 wins next. Requester 3 does not win twice while requester 0 is waiting.
- Backpressure:
  - Stimulus: data_out_ready toggles 1, 0, 0, 1, ... during a vector.
  - Response: beats are never skipped or duplicated, outputs are stable during stalls, and exactly 4 handshakes occur per vector.
- Reset mid-vector: asserting rst after beat 1 immediately clears data_out_valid. After release, no stale beats are emitted and the first grant goes to the lowest-index valid requester.
- Configuration NUM_REQ=3, NUM=ROLL_NUM=4: every beat has last = 1, rr_ptr wraps 2 -> 0, and the SRC_W = 2 tag values are 0, 1, 2.
